// File: rtl/mux_5bit.sv
// rtl/mux_5bit.sv - registered 4-to-1 operand selector with asynchronous clear
module mux_5bit #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] chosen;

  // Full decode so synthesis never sees an incomplete case.
  always_comb begin
    chosen = a;
    unique case (select)
      2'b00:   chosen = a;
      2'b01:   chosen = b;
      2'b10:   chosen = c;
      2'b11:   chosen = d;
      default: chosen = a;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= '0;
    end else begin
      out <= chosen;
    end
  end

endmodule

// File: tb/tb_mux_5bit.sv
// tb/tb_mux_5bit.sv - self-checking bench for mux_5bit against an operand-table model
module tb_mux_5bit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] a, b, c, d;
  logic [1:0] select;
  logic [4:0] out;

  int vectors = 0;
  int miscompares = 0;

  mux_5bit #(.WIDTH(5)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .c(c), .d(d),
    .select(select), .out(out)
  );

  always #5 clk = ~clk;

  // Reference: the operand table indexed by the select value.
  function automatic logic [4:0] model_pick(input logic [1:0] s, input logic [4:0] va,
                                            input logic [4:0] vb, input logic [4:0] vc,
                                            input logic [4:0] vd);
    logic [4:0] table_ops [4];
    table_ops[0] = va;
    table_ops[1] = vb;
    table_ops[2] = vc;
    table_ops[3] = vd;
    return table_ops[s];
  endfunction

  task automatic set_plan_operands();
    a = 5'b10000; b = 5'b00010; c = 5'b00000; d = 5'b01101;
  endtask

  task automatic test_reset();
    @(negedge clk);
    set_plan_operands();
    select = 2'b00;
    reset = 1'b1;
    #1;
    vectors++;
    if (out !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_immediate: out=%b expected=%b", out, 5'b00000);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (out !== 5'b00000) begin
        miscompares++;
        $display("FAIL reset_hold_edge%0d: out=%b expected=%b", i, out, 5'b00000);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    vectors++;
    if (out !== 5'b00000) begin
      miscompares++;
      $display("FAIL reset_release_before_edge: out=%b expected=%b", out, 5'b00000);
    end
  endtask

  task automatic test_walk();
    for (int s = 0; s < 4; s++) begin
      logic [4:0] exp_val;
      @(negedge clk);
      set_plan_operands();
      select = 2'(s);
      exp_val = model_pick(2'(s), a, b, c, d);
      @(posedge clk); #1;
      vectors++;
      if (out !== exp_val) begin
        miscompares++;
        $display("FAIL walk_sel%0d: out=%b expected=%b", s, out, exp_val);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    set_plan_operands();
    select = 2'b00;
    @(posedge clk); #1;
    @(negedge clk);
    select = 2'b11;
    #1;
    vectors++;
    if (out !== 5'b10000) begin
      miscompares++;
      $display("FAIL latency_mid_cycle: out=%b expected=%b", out, 5'b10000);
    end
    @(posedge clk); #1;
    vectors++;
    if (out !== 5'b01101) begin
      miscompares++;
      $display("FAIL latency_after_edge: out=%b expected=%b", out, 5'b01101);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    set_plan_operands();
    select = 2'b01;
    @(posedge clk); #1;
    vectors++;
    if (out !== 5'b00010) begin
      miscompares++;
      $display("FAIL hold_initial: out=%b expected=%b", out, 5'b00010);
    end
    @(negedge clk);
    b = 5'b11111;
    #1;
    vectors++;
    if (out !== 5'b00010) begin
      miscompares++;
      $display("FAIL hold_between_edges: out=%b expected=%b", out, 5'b00010);
    end
    @(posedge clk); #1;
    vectors++;
    if (out !== 5'b11111) begin
      miscompares++;
      $display("FAIL hold_after_edge: out=%b expected=%b", out, 5'b11111);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    set_plan_operands();
    select = 2'b11;
    @(posedge clk); #1;
    vectors++;
    if (out !== 5'b01101) begin
      miscompares++;
      $display("FAIL async_preload: out=%b expected=%b", out, 5'b01101);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (out !== 5'b00000) begin
      miscompares++;
      $display("FAIL async_assert_no_edge: out=%b expected=%b", out, 5'b00000);
    end
    @(negedge clk);
    reset = 1'b0;
    select = 2'b00;
    @(posedge clk); #1;
    vectors++;
    if (out !== 5'b10000) begin
      miscompares++;
      $display("FAIL async_first_post_release: out=%b expected=%b", out, 5'b10000);
    end
  endtask

  task automatic test_random();
    logic [4:0] prev_exp;
    logic [4:0] exp_val;
    prev_exp = out;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      a = 5'($urandom);
      b = 5'($urandom);
      c = 5'($urandom);
      d = 5'($urandom);
      select = (i < 4) ? 2'(i) : 2'($urandom_range(0, 3));
      exp_val = model_pick(select, a, b, c, d);
      #1;
      vectors++;
      if (out !== prev_exp) begin
        miscompares++;
        $display("FAIL random_hold_%0d: out=%b expected=%b", i, out, prev_exp);
      end
      @(posedge clk); #1;
      vectors++;
      if (out !== exp_val) begin
        miscompares++;
        $display("FAIL random_edge_%0d sel=%0d: out=%b expected=%b", i, select, out, exp_val);
      end
      prev_exp = exp_val;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] seq [4];
    logic [4:0] exp_val;
    seq[0] = 2'b11; seq[1] = 2'b00; seq[2] = 2'b10; seq[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = 5'b00001; b = 5'b00110; c = 5'b11000; d = 5'b10101;
      select = seq[i];
      exp_val = model_pick(seq[i], a, b, c, d);
      @(posedge clk); #1;
      vectors++;
      if (out !== exp_val) begin
        miscompares++;
        $display("FAIL back_to_back_%0d: out=%b expected=%b", i, out, exp_val);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    select = 2'b00;
    a = '0; b = '0; c = '0; d = '0;
    test_reset();
    test_walk();
    test_latency();
    test_hold();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
